decode_byte_window: RTL and testbench

//  Producer end of the decoder's byte-consume protocol. Buffers instruction bytes from prefetch
//  and presents a 12-byte little-endian window (decoder[95:0]) to the command decoder. On each

---
 rtl/decode_byte_window.sv | 125 ++++++++++++
 tb/tb_decode_byte_window.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_byte_window.sv
// Byte window between prefetch and decode: appends fetch beats and drops consumed bytes in one cycle.
// Latency: one cycle, registered outputs; fetch_accept is combinational from state and flush only.
// Backpressure: fetch_accept drops when fewer than a full beat of space remains or on flush; optional stats under DECODE_WINDOW_STATS_EN.
module decode_byte_window #(
  parameter int WINDOW_BYTES = 12,
  parameter int FETCH_BYTES  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        fetch_valid,
  input  logic [8*FETCH_BYTES-1:0]    fetch_data,
  input  logic [3:0]                  fetch_length,
  output logic                        fetch_accept,
  input  logic                        flush,
  input  logic [31:0]                 flush_eip,
  input  logic                        dec_consume,
  input  logic [3:0]                  dec_consume_count,
  output logic [8*WINDOW_BYTES-1:0]   decoder,
  output logic [3:0]                  decoder_count,
  output logic [31:0]                 dec_eip,
  output logic                        consume_overrun
`ifdef DECODE_WINDOW_STATS_EN
  ,
  output logic [15:0]                 starve_cycles,
  output logic [15:0]                 fetch_stall_cycles
`endif
);

  localparam int WB = 8 * WINDOW_BYTES;
  localparam int FB = 8 * FETCH_BYTES;
  localparam logic [31:0] RESET_EIP = 32'h0000_FFF0;

  logic [WB-1:0] win_q, win_d;
  logic [3:0]    count_q, count_d;
  logic [31:0]   eip_q, eip_d;
  logic          overrun_q, overrun_d;

  logic [FB-1:0] beat_m;
  logic [3:0]    len_eff, app_len, c_req, c_eff, rem;
  logic          take, over;
  logic [WB-1:0] shifted, appended;

  assign fetch_accept = !flush && (count_q <= 4'(WINDOW_BYTES - FETCH_BYTES));
  assign take         = fetch_valid && fetch_accept;
  assign len_eff      = (fetch_length > 4'(FETCH_BYTES)) ? 4'(FETCH_BYTES) : fetch_length;
  assign app_len      = take ? len_eff : 4'd0;

  // Over-long consumes are clipped to what is held and reported the following cycle.
  assign c_req = dec_consume ? dec_consume_count : 4'd0;
  assign over  = c_req > count_q;
  assign c_eff = over ? count_q : c_req;
  assign rem   = count_q - c_eff;

  always_comb begin
    beat_m = '0;
    for (int k = 0; k < FETCH_BYTES; k++) begin
      if (4'(k) < len_eff) beat_m[8*k +: 8] = fetch_data[8*k +: 8];
    end
  end

  // Bytes above the live count are always zero, so OR-merging the beat is safe.
  assign shifted  = win_q >> {c_eff, 3'b000};
  assign appended = take ? ({{(WB-FB){1'b0}}, beat_m} << {rem, 3'b000}) : '0;

  always_comb begin
    win_d     = shifted | appended;
    count_d   = rem + app_len;
    eip_d     = eip_q + {28'd0, c_eff};
    overrun_d = over;
    if (flush) begin
      win_d     = '0;
      count_d   = 4'd0;
      eip_d     = flush_eip;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q     <= '0;
      count_q   <= 4'd0;
      eip_q     <= RESET_EIP;
      overrun_q <= 1'b0;
    end else begin
      win_q     <= win_d;
      count_q   <= count_d;
      eip_q     <= eip_d;
      overrun_q <= overrun_d;
    end
  end

  assign decoder         = win_q;
  assign decoder_count   = count_q;
  assign dec_eip         = eip_q;
  assign consume_overrun = overrun_q;

`ifdef DECODE_WINDOW_STATS_EN
  logic [15:0] starve_q, starve_d;
  logic [15:0] stall_q, stall_d;

  always_comb begin
    starve_d = starve_q;
    if (flush) starve_d = 16'd0;
    else if ((count_q == 4'd0) && (starve_q != 16'hFFFF)) starve_d = starve_q + 16'd1;
    stall_d = stall_q;
    if (fetch_valid && !fetch_accept && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= 16'd0;
      stall_q  <= 16'd0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign starve_cycles      = starve_q;
  assign fetch_stall_cycles = stall_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_decode_byte_window.sv
// Directed bench for decode_byte_window: fill, drain, overrun, flush and async reset cases.
module tb_decode_byte_window;

  logic        clk;
  logic        rst_n;
  logic        fetch_valid;
  logic [63:0] fetch_data;
  logic [3:0]  fetch_length;
  logic        fetch_accept;
  logic        flush;
  logic [31:0] flush_eip;
  logic        dec_consume;
  logic [3:0]  dec_consume_count;
  logic [95:0] decoder;
  logic [3:0]  decoder_count;
  logic [31:0] dec_eip;
  logic        consume_overrun;
`ifdef DECODE_WINDOW_STATS_EN
  logic [15:0] starve_cycles;
  logic [15:0] fetch_stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  decode_byte_window dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .fetch_valid       (fetch_valid),
    .fetch_data        (fetch_data),
    .fetch_length      (fetch_length),
    .fetch_accept      (fetch_accept),
    .flush             (flush),
    .flush_eip         (flush_eip),
    .dec_consume       (dec_consume),
    .dec_consume_count (dec_consume_count),
    .decoder           (decoder),
    .decoder_count     (decoder_count),
    .dec_eip           (dec_eip),
    .consume_overrun   (consume_overrun)
`ifdef DECODE_WINDOW_STATS_EN
    ,
    .starve_cycles     (starve_cycles),
    .fetch_stall_cycles(fetch_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fetch_valid = 1'b0; fetch_data = '0; fetch_length = 4'd0;
    flush = 1'b0; flush_eip = '0;
    dec_consume = 1'b0; dec_consume_count = 4'd0;
  endtask

  task automatic beat(input logic [63:0] d, input logic [3:0] l);
    fetch_valid = 1'b1; fetch_data = d; fetch_length = l;
  endtask

  task automatic consume(input logic [3:0] c);
    dec_consume = 1'b1; dec_consume_count = c;
  endtask

  task automatic chk_state(input string tag, input logic [3:0] cnt, input logic [95:0] win,
                           input logic [31:0] eip);
    chk({tag, ".count"}, 96'(decoder_count), 96'(cnt));
    chk({tag, ".decoder"}, decoder, win);
    chk({tag, ".eip"}, 96'(dec_eip), 96'(eip));
  endtask

  initial begin
    idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk_state("reset", 4'd0, 96'h0, 32'h0000_FFF0);
    chk("reset.overrun", 96'(consume_overrun), 96'h0);
    chk("reset.accept", 96'(fetch_accept), 96'h1);
    tick(); tick();
    rst_n = 1'b1;

    // Fill to exactly 4, then a full beat to reach 12.
    beat(64'hEEEE_EEEE_0403_0201, 4'd4);
    tick();
    chk_state("fill4", 4'd4, 96'h0403_0201, 32'h0000_FFF0);
    beat(64'h0C0B_0A09_0807_0605, 4'd8);
    #1 chk("fill4.accept", 96'(fetch_accept), 96'h1);
    tick();
    chk_state("fill12", 4'd12, 96'h0C0B0A09_08070605_04030201, 32'h0000_FFF0);
    chk("fill12.accept", 96'(fetch_accept), 96'h0);

    // Full window refuses the beat while consume still drains.
    beat(64'h1111_1111_1111_1111, 4'd4);
    consume(4'd3);
    tick();
    chk_state("cons3", 4'd9, 96'h0C_0B0A0908_07060504, 32'h0000_FFF3);
    chk("cons3.byte0", 96'(decoder[7:0]), 96'h04);

    beat(64'h0000_0000_0000_BBAA, 4'd2);
    consume(4'd5);
    tick();
    chk_state("cons5", 4'd4, 96'h0C0B_0A09, 32'h0000_FFF8);

    dec_consume = 1'b0;
    tick();
    chk_state("app2", 4'd6, 96'hBBAA_0C0B_0A09, 32'h0000_FFF8);

    fetch_valid = 1'b0;
    consume(4'd2);
    tick();
    chk_state("cons2", 4'd4, 96'hBBAA_0C0B, 32'h0000_FFFA);

    // Simultaneous consume and append; junk above the beat length is dropped.
    beat(64'hFFFF_FFFF_FF33_2211, 4'd3);
    consume(4'd2);
    tick();
    chk_state("both", 4'd5, 96'h33_2211_BBAA, 32'h0000_FFFC);

    fetch_valid = 1'b0;
    consume(4'd3);
    tick();
    chk_state("cons3b", 4'd2, 96'h3322, 32'h0000_FFFF);
    chk("cons3b.overrun", 96'(consume_overrun), 96'h0);

    consume(4'd5);
    tick();
    chk_state("overrun", 4'd0, 96'h0, 32'h0001_0001);
    chk("overrun.flag", 96'(consume_overrun), 96'h1);

    consume(4'd4);
    tick();
    chk_state("empty", 4'd0, 96'h0, 32'h0001_0001);
    chk("empty.flag", 96'(consume_overrun), 96'h1);

    dec_consume = 1'b0;
    tick();
    chk("pulse.end", 96'(consume_overrun), 96'h0);

    // Length above 8 is clipped to a full beat.
    beat(64'h8877_6655_4433_2211, 4'd15);
    tick();
    chk_state("len15", 4'd8, 96'h8877_6655_4433_2211, 32'h0001_0001);

    fetch_valid = 1'b0;
    consume(4'd0);
    tick();
    chk_state("cons0", 4'd8, 96'h8877_6655_4433_2211, 32'h0001_0001);
    chk("cons0.overrun", 96'(consume_overrun), 96'h0);

    consume(4'd5);
    tick();
    chk_state("cons5b", 4'd3, 96'h88_7766, 32'h0001_0006);

    // Flush wins over a pending beat and an overrunning consume.
    flush = 1'b1; flush_eip = 32'h0000_1000;
    beat(64'h55, 4'd1);
    consume(4'd5);
    #1 chk("flush.accept", 96'(fetch_accept), 96'h0);
    tick();
    chk_state("flush", 4'd0, 96'h0, 32'h0000_1000);
    chk("flush.overrun", 96'(consume_overrun), 96'h0);

    idle();
    #1 chk("postflush.accept", 96'(fetch_accept), 96'h1);
    tick();
    chk_state("postflush", 4'd0, 96'h0, 32'h0000_1000);

    beat(64'h4433_2211, 4'd4);
    tick();
    beat(64'h0077_6655, 4'd3);
    tick();
    idle();
    chk_state("refill7", 4'd7, 96'h77_6655_4433_2211, 32'h0000_1000);

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1;
    chk_state("areset", 4'd0, 96'h0, 32'h0000_FFF0);
    chk("areset.accept", 96'(fetch_accept), 96'h1);
    tick();
    rst_n = 1'b1;

`ifdef DECODE_WINDOW_STATS_EN
    repeat (20) tick();
    chk("starve20", 96'(starve_cycles), 96'd20);
    chk("stall0", 96'(fetch_stall_cycles), 96'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
